// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the MIPS front end: word type, NOP encoding,
// opcode constants and instruction field positions.
package if_stage_pkg;

    typedef logic [31:0] word_t;

    localparam word_t NOP_WORD = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 26;
    localparam int IMM16_MSB   = 15;
    localparam int IMM16_LSB   = 0;
    localparam int INDEX26_MSB = 25;
    localparam int INDEX26_LSB = 0;

    // Branch offsets count words, so the sign-extended field is scaled to bytes.
    function automatic word_t sign_ext_shift2(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC candidates: sequential, branch and jump targets,
// all wrapped into the instruction memory address range.
module if_next_pc
    import if_stage_pkg::*;
#(
    parameter int IMEM_BYTES = 256
) (
    input  word_t       pc,
    input  word_t       if_id_pc_plus4,
    input  logic [15:0] branch_imm16,
    input  logic [25:0] jump_index26,
    input  logic        branch_taken,
    input  logic        jump,
    output word_t       seq_pc,
    output word_t       redirect_pc,
    output logic        redirect
);

    localparam word_t ADDR_MASK = word_t'(IMEM_BYTES - 1);

    word_t branch_target;
    word_t jump_target;

    assign seq_pc        = (pc + 32'd4) & ADDR_MASK;
    assign branch_target = (if_id_pc_plus4 + sign_ext_shift2(branch_imm16)) & ADDR_MASK;
    assign jump_target   = {if_id_pc_plus4[31:28], jump_index26, 2'b00} & ADDR_MASK;

    // A jump outranks a simultaneous taken branch.
    assign redirect    = jump | branch_taken;
    assign redirect_pc = jump ? jump_target : branch_target;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a count
// of valid instructions handed to decode.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 256,
    parameter logic [31:0] NOP_WORD   = if_stage_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm16,
    input  logic        jump,
    input  logic [25:0] jump_index26,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);
    import if_stage_pkg::*;

    word_t pc_reg;
    word_t if_id_instr_reg;
    word_t if_id_pc_plus4_reg;
    logic  if_id_valid_reg;
    word_t fetch_count_reg;

    word_t seq_pc;
    word_t redirect_pc;
    logic  redirect;

    if_next_pc #(
        .IMEM_BYTES(IMEM_BYTES)
    ) u_next_pc (
        .pc             (pc_reg),
        .if_id_pc_plus4 (if_id_pc_plus4_reg),
        .branch_imm16   (branch_imm16),
        .jump_index26   (jump_index26),
        .branch_taken   (branch_taken),
        .jump           (jump),
        .seq_pc         (seq_pc),
        .redirect_pc    (redirect_pc),
        .redirect       (redirect)
    );

    // Stall freezes everything, including redirects whose operands are not ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg             <= RESET_PC;
            if_id_instr_reg    <= NOP_WORD;
            if_id_pc_plus4_reg <= '0;
            if_id_valid_reg    <= 1'b0;
            fetch_count_reg    <= '0;
        end else if (!stall) begin
            if (redirect) begin
                pc_reg             <= redirect_pc;
                if_id_instr_reg    <= NOP_WORD;
                if_id_pc_plus4_reg <= '0;
                if_id_valid_reg    <= 1'b0;
            end else begin
                pc_reg             <= seq_pc;
                if_id_instr_reg    <= imem_instr;
                if_id_pc_plus4_reg <= seq_pc;
                if_id_valid_reg    <= 1'b1;
                fetch_count_reg    <= fetch_count_reg + 32'd1;
            end
        end
    end

    assign imem_addr      = pc_reg;
    assign pc             = pc_reg;
    assign if_id_instr    = if_id_instr_reg;
    assign if_id_pc_plus4 = if_id_pc_plus4_reg;
    assign if_id_valid    = if_id_valid_reg;
    assign fetch_count    = fetch_count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a table of per-edge vectors plus a hand-written
// asynchronous-reset sequence.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm16;
    logic        jump;
    logic [25:0] jump_index26;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem [64];

    if_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (256),
        .NOP_WORD   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_imm16   (branch_imm16),
        .jump           (jump),
        .jump_index26   (jump_index26),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_count    (fetch_count)
    );

    assign imem_instr = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input int idx);
        return {16'hC0DE, 8'h00, 8'(idx)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pp4, input logic e_valid,
                           input logic [31:0] e_cnt);
        chk("pc", pc, e_pc);
        chk("imem_addr", imem_addr, e_pc);
        chk("if_id_instr", if_id_instr, e_instr);
        chk("if_id_pc_plus4", if_id_pc_plus4, e_pp4);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e_valid});
        chk("fetch_count", fetch_count, e_cnt);
    endtask

    // Decode may only redirect while it holds a real instruction.
    always @(posedge clk) begin
        if (!rst && (jump || branch_taken)) begin
            n_cmp++;
            if (!if_id_valid) begin
                n_fail++;
                $display("FAIL redirect_qual: redirect raised with if_id_valid=%0b, expected 1", if_id_valid);
            end
        end
    end

    typedef struct {
        logic        stall;
        logic        jump;
        logic        branch_taken;
        logic [15:0] imm16;
        logic [25:0] idx26;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pp4;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = w(i);

        //          stall jump br   imm16     idx26          pc     instr   pp4    v  cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 26'h0,       32'd4,   w(0),  32'd4,   1'b1, 32'd1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0008, 26'h0,       32'd36,  32'h0, 32'd0,   1'b0, 32'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 26'h0,       32'd40,  w(9),  32'd40,  1'b1, 32'd2};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h0001, 26'h8,       32'd32,  32'h0, 32'd0,   1'b0, 32'd2};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 26'h0,       32'd36,  w(8),  32'd36,  1'b1, 32'd3};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 26'h3E,      32'd36,  w(8),  32'd36,  1'b1, 32'd3};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 26'h3E,      32'd36,  w(8),  32'd36,  1'b1, 32'd3};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 26'h3E,      32'd248, 32'h0, 32'd0,   1'b0, 32'd3};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 26'h0,       32'd252, w(62), 32'd252, 1'b1, 32'd4};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 26'h0,       32'd0,   w(63), 32'd0,   1'b1, 32'd5};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 26'h0,       32'd4,   w(0),  32'd4,   1'b1, 32'd6};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 26'h0,       32'd8,   w(1),  32'd8,   1'b1, 32'd7};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 16'hFFFE, 26'h0,       32'd0,   32'h0, 32'd0,   1'b0, 32'd7};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 26'h0,       32'd4,   w(0),  32'd4,   1'b1, 32'd8};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 16'h0040, 26'h0,       32'd4,   32'h0, 32'd0,   1'b0, 32'd8};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 26'h0,       32'd8,   w(1),  32'd8,   1'b1, 32'd9};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 26'h3FFFFFF, 32'd252, 32'h0, 32'd0,   1'b0, 32'd9};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 26'h0,       32'd0,   w(63), 32'd0,   1'b1, 32'd10};

        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_imm16 = '0;
        jump = 1'b0;
        jump_index26 = '0;

        @(negedge clk);
        @(negedge clk);
        chk_all(32'd0, 32'h0, 32'd0, 1'b0, 32'd0);
        $display("reset: pc=%h instr=%h pp4=%h valid=%0b count=%0d",
                 pc, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            stall        = vecs[i].stall;
            jump         = vecs[i].jump;
            branch_taken = vecs[i].branch_taken;
            branch_imm16 = vecs[i].imm16;
            jump_index26 = vecs[i].idx26;
            @(posedge clk);
            #1;
            chk_all(vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pp4, vecs[i].e_valid, vecs[i].e_cnt);
            $display("vec %0d: st=%0b j=%0b br=%0b -> pc=%h instr=%h pp4=%h valid=%0b count=%0d",
                     i, vecs[i].stall, vecs[i].jump, vecs[i].branch_taken,
                     pc, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count);
            @(negedge clk);
        end

        // Asynchronous reset asserted between edges during a stall.
        stall = 1'b1;
        jump = 1'b0;
        branch_taken = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_all(32'd0, 32'h0, 32'd0, 1'b0, 32'd0);
        $display("async reset: pc=%h instr=%h pp4=%h valid=%0b count=%0d",
                 pc, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count);
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk_all(32'd4, w(0), 32'd4, 1'b1, 32'd1);
        $display("after release: pc=%h instr=%h pp4=%h valid=%0b count=%0d",
                 pc, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program counter, drives the byte address into the instruction memory, and captures the returned big-endian 32-bit word into the IF/ID pipeline register. Takes stall from the hazard unit and branch/jump redirects resolved in ID; redirect targets are computed locally.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_BYTES, 256, instruction memory size in bytes; power of two, at least 8; PC wraps modulo this value.
NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush/reset (sll $0,$0,0).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset.
imem_addr  out  32  byte address to instruction memory; equals pc.
imem_instr  in  32  combinational read data for imem_addr.
stall  in  1  hazard unit: hold PC and IF/ID (load-use).
branch_taken  in  1  ID: conditional branch resolved taken.
branch_imm16  in  16  ID: branch offset field (words).
jump  in  1  ID: j instruction.
jump_index26  in  26  ID: jump target field.
pc  out  32  current PC register.
if_id_instr  out  32  IF/ID instruction.
if_id_pc_plus4  out  32  IF/ID PC+4 of captured instruction.
if_id_valid  out  1  IF/ID holds a real instruction.
fetch_count  out  32  number of valid instructions captured into IF/ID.

Behaviour:
- Reset (async, any time, including mid-redirect or stall): pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc_plus4=0, if_id_valid=0, fetch_count=0. First fetch happens at the first rising edge after rst deasserts.
- imem_addr = pc combinationally; no extra latency. The memory is byte-addressed with a combinational read.
- seq_pc = (pc + 4) mod IMEM_BYTES.
- Branch target = (if_id_pc_plus4 + (sign_extend(branch_imm16) << 2)) mod IMEM_BYTES.
- Jump target = {if_id_pc_plus4[31:28], jump_index26, 2'b00} mod IMEM_BYTES.
- Per rising edge, the first matching case in this priority order applies:
  1. stall=1: pc, if_id_* and fetch_count hold. Any branch_taken/jump in the same cycle is ignored, because the ID instruction's operands are not yet valid. The ID stage re-presents the redirect after the stall.
  2. jump=1 (jump wins over branch_taken): pc<=jump target; if_id_instr<=NOP_WORD, if_id_valid<=0, if_id_pc_plus4<=0.
  3. branch_taken=1: same as case 2, using the branch target.
  4. otherwise: if_id_instr<=imem_instr, if_id_pc_plus4<=seq_pc, if_id_valid<=1, pc<=seq_pc, fetch_count<=fetch_count+1.
- Redirect penalty is exactly one bubble: the word fetched in the redirect cycle is discarded.
- branch_taken/jump are qualified only by the stall rule above. ID must only raise them while its own if_id_valid=1; the bench checks this with an assertion.
- pc[1:0] is always 00; every source of pc is word-aligned by construction.
- Wrap-around: pc = IMEM_BYTES-4 followed by a sequential fetch gives pc=0 and if_id_pc_plus4=0.
- fetch_count wraps modulo 2^32.

Decomposition:
- Shared pipeline package holds NOP_WORD, the opcode constants OP_J=6'b000010 and OP_BEQ=6'b000100, the instruction field slice positions, and a 32-bit word typedef.
- One natural sub-module, if_next_pc: purely combinational selection of seq, branch and jump targets with wrap masking. The PC register, IF/ID register and counter stay in if_stage.

Test Plan:
- Reset then free-run, memory preloaded with words W0..W3 at 0,4,8,12 -> pc sequence 0,4,8,12; IF/ID shows W0 with pc_plus4=4 one cycle after reset release; fetch_count=4 after 4 edges.
- Branch: branch_taken=1, branch_imm16=16'h0008, if_id_pc_plus4=4 -> next pc=36 (0x24); IF/ID holds NOP with valid=0 for one cycle; then the word at 36 appears with pc_plus4=40.
- Jump vs branch: jump=1, jump_index26=26'h8 and branch_taken=1 together -> pc=32; branch ignored; one bubble.
- Stall with redirect: stall=1 for 2 cycles with jump=1 -> pc, IF/ID and fetch_count unchanged both cycles; stall=0 with jump=1 -> redirect taken.
- Wrap and negative offset: pc=252 sequential -> pc=0, pc_plus4=0. Branch with imm 16'hFFFE at pc_plus4=8 -> target 0.
- Async reset mid-operation: assert rst between edges during a stall -> outputs take their reset values immediately, without waiting for a clock edge.
